comm_frame_transmitter: RTL and testbench

- Downlink-side frame transmitter: the counterpart of the comm receiver's start-byte detection and decoding.
- Accepts one 32-bit response word per frame over a valid/ready handshake and frames it as start byte + 32 data bits + CRC-8.
- Manchester-encodes the frame onto the 12-bit comm DAC and holds comm_dac_on for the whole frame plus a guard interval, so the receive path can blank itself.

---
 rtl/comm_frame_transmitter_if.sv | 22 ++
 rtl/comm_frame_transmitter.sv | 167 ++++++++++++++++
 tb/tb_comm_frame_transmitter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comm_frame_transmitter_if.sv
// Response-word handshake between the command processor and the downlink
// frame transmitter.
//   tx_word  : 32-bit response word, master -> slave
//   tx_valid : tx_word valid, master -> slave
//   tx_ready : slave accepts tx_word this cycle, slave -> master
interface comm_frame_transmitter_if;
   logic [31:0] tx_word;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output tx_word,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_word,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/comm_frame_transmitter.sv
// Downlink frame transmitter. Accepts one 32-bit word per frame, frames it as
// START_BYTE + 32 data bits (MSB first) + CRC-8 (poly 0x07, init 0x00, MSB
// first), Manchester-encodes it onto the comm DAC, then idles the DAC for
// GUARD_CLKS cycles with comm_dac_on still asserted so the receive path can
// blank itself.
// CLKS_PER_BIT must be even and at least 4.
//   inclk       : system clock
//   rst_n       : asynchronous active-low reset
//   tx_if       : slave side of the tx_word/tx_valid/tx_ready handshake
//   com_dac     : registered 12-bit DAC code
//   comm_dac_on : registered, high from the first half-bit through the guard
//   busy        : state is not IDLE
//   frame_done  : one-cycle pulse on return to IDLE
module comm_frame_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 20,
   parameter logic [7:0]  START_BYTE   = 8'b10101011,
   parameter logic [11:0] DAC_HIGH     = 12'hC00,
   parameter logic [11:0] DAC_LOW      = 12'h400,
   parameter logic [11:0] DAC_IDLE     = 12'h800,
   parameter int unsigned GUARD_CLKS   = 40
) (
   input  logic                      inclk,
   input  logic                      rst_n,
   comm_frame_transmitter_if.slave   tx_if,
   output logic [11:0]               com_dac,
   output logic                      comm_dac_on,
   output logic                      busy,
   output logic                      frame_done
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned GW = (GUARD_CLKS > 1) ? $clog2(GUARD_CLKS) : 1;

   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2);
   localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CLKS > 0) ? GUARD_CLKS - 1 : 0);

   // Bit index of the last bit of each frame section (48 bits in total).
   localparam logic [5:0] LAST_START_BIT = 6'd7;
   localparam logic [5:0] LAST_DATA_BIT  = 6'd39;
   localparam logic [5:0] LAST_CRC_BIT   = 6'd47;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_CRC,
      S_GUARD
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    bit_q, bit_d;
   logic [GW-1:0] guard_q, guard_d;
   logic [47:0]   frame_q, frame_d;
   logic [11:0]   dac_q, dac_d;
   logic          on_q, on_d;
   logic          done_q, done_d;
   logic          tx_ready;

   // CRC-8, poly 0x07, init 0, no reflection, no final XOR, data MSB first.
   function automatic logic [7:0] crc8(input logic [31:0] data);
      logic [7:0]  c;
      logic [31:0] d;
      logic        fb;
      c = '0;
      d = data;
      for (int unsigned i = 0; i < 32; i++) begin
         fb = c[7] ^ d[31];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         d  = {d[30:0], 1'b0};
      end
      return c;
   endfunction

   assign tx_ready       = (state_q == S_IDLE) & rst_n;
   assign tx_if.tx_ready = tx_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      guard_d = guard_q;
      frame_d = frame_q;

      case (state_q)
         S_IDLE: begin
            if (tx_if.tx_valid && tx_ready) begin
               // Start byte, word and CRC share one shift register; bit 47
               // is always the bit currently on the line.
               state_d = S_START;
               frame_d = {START_BYTE, tx_if.tx_word, crc8(tx_if.tx_word)};
               cnt_d   = '0;
               bit_d   = '0;
            end
         end

         S_START, S_DATA, S_CRC: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               bit_d   = bit_q + 6'd1;
               frame_d = {frame_q[46:0], 1'b0};
               if (bit_q == LAST_START_BIT) begin
                  state_d = S_DATA;
               end else if (bit_q == LAST_DATA_BIT) begin
                  state_d = S_CRC;
               end else if (bit_q == LAST_CRC_BIT) begin
                  state_d = (GUARD_CLKS == 0) ? S_IDLE : S_GUARD;
                  bit_d   = '0;
                  guard_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_GUARD: begin
            if (guard_q == GUARD_LAST) begin
               state_d = S_IDLE;
            end else begin
               guard_d = guard_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the next-state
      // values: the cycle after accept already shows the first half-bit.
      dac_d = DAC_IDLE;
      if (state_d inside {S_START, S_DATA, S_CRC}) begin
         dac_d = (frame_d[47] == (cnt_d < CNT_HALF)) ? DAC_HIGH : DAC_LOW;
      end
      on_d   = (state_d != S_IDLE);
      done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
   end

   always_ff @(posedge inclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         guard_q <= '0;
         frame_q <= '0;
         dac_q   <= DAC_IDLE;
         on_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         guard_q <= guard_d;
         frame_q <= frame_d;
         dac_q   <= dac_d;
         on_q    <= on_d;
         done_q  <= done_d;
      end
   end

   assign com_dac     = dac_q;
   assign comm_dac_on = on_q;
   assign busy        = (state_q != S_IDLE);
   assign frame_done  = done_q;

endmodule

// File: tb/tb_comm_frame_transmitter.sv
// Bench for comm_frame_transmitter: a default instance and a CLKS_PER_BIT=4,
// GUARD_CLKS=0 instance, each checked every cycle against a waveform queue
// built from the frame rules.
module tb_comm_frame_transmitter;
   localparam int NCFG = 2;
   localparam logic [7:0]  START_BYTE = 8'b10101011;
   localparam logic [11:0] DAC_HIGH   = 12'hC00;
   localparam logic [11:0] DAC_LOW    = 12'h400;
   localparam logic [11:0] DAC_IDLE   = 12'h800;

   function automatic int cpb(input int g);
      return (g == 0) ? 20 : 4;
   endfunction

   function automatic int gclks(input int g);
      return (g == 0) ? 40 : 0;
   endfunction

   logic inclk = 1'b0;
   logic rst_n = 1'b0;
   always #5 inclk = ~inclk;

   logic [31:0] word_s [NCFG];
   logic        valid_s [NCFG];
   logic        ready [NCFG];
   logic [11:0] dac [NCFG];
   logic        on_o [NCFG];
   logic        busy [NCFG];
   logic        done [NCFG];

   comm_frame_transmitter_if bus0 ();
   comm_frame_transmitter_if bus1 ();

   assign bus0.tx_word  = word_s[0];
   assign bus0.tx_valid = valid_s[0];
   assign ready[0]      = bus0.tx_ready;
   assign bus1.tx_word  = word_s[1];
   assign bus1.tx_valid = valid_s[1];
   assign ready[1]      = bus1.tx_ready;

   comm_frame_transmitter dut0 (
      .inclk       (inclk),
      .rst_n       (rst_n),
      .tx_if       (bus0),
      .com_dac     (dac[0]),
      .comm_dac_on (on_o[0]),
      .busy        (busy[0]),
      .frame_done  (done[0])
   );

   comm_frame_transmitter #(.CLKS_PER_BIT(4), .GUARD_CLKS(0)) dut1 (
      .inclk       (inclk),
      .rst_n       (rst_n),
      .tx_if       (bus1),
      .com_dac     (dac[1]),
      .comm_dac_on (on_o[1]),
      .busy        (busy[1]),
      .frame_done  (done[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Expected {comm_dac_on, com_dac} for each upcoming cycle of a frame.
   logic [12:0] exp_q [NCFG][$];
   logic        prev_on [NCFG] = '{1'b0, 1'b0};
   int          on_run [NCFG] = '{0, 0};
   int          off_run [NCFG] = '{0, 0};
   int          last_on_len [NCFG] = '{0, 0};
   int          last_gap [NCFG] = '{0, 0};
   int          done_cnt [NCFG] = '{0, 0};

   // CRC by polynomial long division of {word, 8'h00} by x^8+x^2+x+1.
   function automatic logic [7:0] ref_crc(input logic [31:0] w);
      logic [39:0] v;
      v = {w, 8'h00};
      for (int i = 39; i >= 8; i--) begin
         if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
      end
      return v[7:0];
   endfunction

   function automatic void push_frame(input int g, input logic [31:0] w);
      logic [47:0] f;
      logic        b;
      f = {START_BYTE, w, ref_crc(w)};
      for (int i = 0; i < 48; i++) begin
         b = f[47 - i];
         for (int c = 0; c < cpb(g); c++) begin
            exp_q[g].push_back({1'b1, ((c < cpb(g) / 2) == b) ? DAC_HIGH : DAC_LOW});
         end
      end
      for (int c = 0; c < gclks(g); c++) exp_q[g].push_back({1'b1, DAC_IDLE});
   endfunction

   task automatic check(input string name, input int g, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cfg%0d at %0t: got %0h, required %0h", name, g, $time, got, want);
      end
   endtask

   always @(posedge inclk) begin
      #1;
      for (int g = 0; g < NCFG; g++) begin
         logic [12:0] e;
         logic        e_done;
         logic [15:0] want;
         logic [15:0] got;
         e = {1'b0, DAC_IDLE};
         if (!rst_n) begin
            exp_q[g].delete();
            e_done = 1'b0;
         end else begin
            if (!prev_on[g] && valid_s[g]) push_frame(g, word_s[g]);
            if (exp_q[g].size() > 0) e = exp_q[g].pop_front();
            e_done = prev_on[g] & ~e[12];
         end
         want = {e[12], e[11:0], e[12], ~e[12] & rst_n, e_done};
         got  = {on_o[g], dac[g], busy[g], ready[g], done[g]};
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL cycle cfg%0d at %0t: got on=%b dac=%h busy=%b ready=%b done=%b, required on=%b dac=%h busy=%b ready=%b done=%b",
                     g, $time, got[15], got[14:3], got[2], got[1], got[0],
                     want[15], want[14:3], want[2], want[1], want[0]);
         end
         prev_on[g] = e[12];

         if (on_o[g]) begin
            if (off_run[g] > 0) last_gap[g] = off_run[g];
            off_run[g] = 0;
            on_run[g]++;
         end else begin
            if (on_run[g] > 0) last_on_len[g] = on_run[g];
            on_run[g] = 0;
            off_run[g]++;
         end
         if (done[g]) done_cnt[g]++;
      end
   end

   // Presents w and returns at the falling edge after the accepting edge.
   task automatic send(input int g, input logic [31:0] w, input bit hold);
      int n;
      n = 0;
      @(negedge inclk);
      word_s[g]  = w;
      valid_s[g] = 1'b1;
      while (!ready[g] && n < 5000) begin
         @(negedge inclk);
         n++;
      end
      check("accept_wait", g, ready[g], 1);
      @(negedge inclk);
      if (!hold) begin
         valid_s[g] = 1'b0;
         word_s[g]  = $urandom();
      end
   endtask

   task automatic wait_idle(input int g);
      int n;
      n = 0;
      while (!ready[g] && n < 5000) begin
         @(negedge inclk);
         n++;
      end
      check("idle_wait", g, ready[g], 1);
   endtask

   task automatic b2b(input int g, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      send(g, a, 1'b1);
      word_s[g] = b;
      while (!ready[g] && n < 5000) begin
         @(negedge inclk);
         n++;
      end
      check("b2b_ready", g, ready[g], 1);
      check("b2b_accept_in_done_cycle", g, done[g], 1);
      @(negedge inclk);
      valid_s[g] = 1'b0;
      word_s[g]  = $urandom();
      check("b2b_gap", g, last_gap[g], 1);
   endtask

   task automatic busy_poke(input int g, input logic [31:0] w, input logic [31:0] other);
      int d;
      d = done_cnt[g];
      send(g, w, 1'b0);
      repeat (3 * cpb(g)) @(negedge inclk);
      word_s[g]  = other;
      valid_s[g] = 1'b1;
      check("ready_while_busy", g, ready[g], 0);
      @(negedge inclk);
      valid_s[g] = 1'b0;
      wait_idle(g);
      check("one_done_after_poke", g, done_cnt[g] - d, 1);
   endtask

   task automatic rand_traffic(input int g, input int nframes);
      for (int i = 0; i < nframes; i++) begin
         repeat ($urandom_range(0, 15)) @(negedge inclk);
         if ($urandom_range(0, 3) == 0) begin
            b2b(g, $urandom(), $urandom());
         end else begin
            send(g, $urandom(), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
               repeat ($urandom_range(1, 24 * cpb(g))) @(negedge inclk);
               word_s[g]  = $urandom();
               valid_s[g] = 1'b1;
               check("ready_while_busy_rand", g, ready[g], 0);
               @(negedge inclk);
               valid_s[g] = 1'b0;
            end
         end
      end
      wait_idle(g);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int d1;
      for (int g = 0; g < NCFG; g++) begin
         valid_s[g] = 1'b0;
         word_s[g]  = '0;
      end

      check("crc_model_0x00000001", 0, ref_crc(32'h0000_0001), 8'h07);
      check("crc_model_0x00000000", 0, ref_crc(32'h0000_0000), 8'h00);

      // Reset state.
      repeat (3) @(negedge inclk);
      for (int g = 0; g < NCFG; g++) begin
         check("reset_dac", g, dac[g], 12'h800);
         check("reset_on", g, on_o[g], 0);
         check("reset_busy", g, busy[g], 0);
         check("reset_ready", g, ready[g], 0);
         check("reset_done", g, done[g], 0);
      end
      rst_n = 1'b1;
      @(posedge inclk);
      #1;
      check("ready_after_reset", 0, ready[0], 1);
      check("ready_after_reset", 1, ready[1], 1);

      // Single frame, word 0x00000001.
      d0 = done_cnt[0];
      d1 = done_cnt[1];
      fork
         send(0, 32'h0000_0001, 1'b0);
         send(1, 32'h0000_0001, 1'b0);
      join
      for (int k = 0; k < 20; k++) begin
         if (k == 0) begin
            check("on_first_cycle", 0, on_o[0], 1);
            check("on_first_cycle", 1, on_o[1], 1);
         end
         if (k == 0 || k == 9)  check("start7_first_half", 0, dac[0], 12'hC00);
         if (k == 10 || k == 19) check("start7_second_half", 0, dac[0], 12'h400);
         if (k == 0 || k == 1)  check("start7_first_half", 1, dac[1], 12'hC00);
         if (k == 2 || k == 3)  check("start7_second_half", 1, dac[1], 12'h400);
         @(negedge inclk);
      end
      wait_idle(0);
      wait_idle(1);
      check("on_length", 0, last_on_len[0], 1000);
      check("on_length", 1, last_on_len[1], 192);
      check("done_pulses", 0, done_cnt[0] - d0, 1);
      check("done_pulses", 1, done_cnt[1] - d1, 1);

      // All-zero word: data bits are LOW then HIGH.
      fork
         send(0, 32'h0000_0000, 1'b0);
         send(1, 32'h0000_0000, 1'b0);
      join
      for (int k = 0; k <= 170; k++) begin
         if (k == 160) check("zero_data_first_half", 0, dac[0], 12'h400);
         if (k == 170) check("zero_data_second_half", 0, dac[0], 12'hC00);
         if (k == 32)  check("zero_data_first_half", 1, dac[1], 12'h400);
         if (k == 34)  check("zero_data_second_half", 1, dac[1], 12'hC00);
         @(negedge inclk);
      end
      wait_idle(0);
      wait_idle(1);

      // Back-to-back with tx_valid held.
      fork
         b2b(0, 32'hDEAD_BEEF, 32'h1234_5678);
         b2b(1, 32'hA5A5_0F0F, 32'h8000_0001);
      join
      wait_idle(0);
      wait_idle(1);

      // tx_valid while busy is ignored.
      fork
         busy_poke(0, 32'hCAFE_F00D, 32'hFFFF_FFFF);
         busy_poke(1, 32'h0F0F_0F0F, 32'h0000_0000);
      join

      // Reset in the middle of the data bits.
      fork
         send(0, $urandom(), 1'b0);
         send(1, $urandom(), 1'b0);
      join
      repeat (13 * 20) @(negedge inclk);
      d0 = done_cnt[0];
      rst_n = 1'b0;
      #1;
      check("midframe_reset_dac", 0, dac[0], 12'h800);
      check("midframe_reset_on", 0, on_o[0], 0);
      check("midframe_reset_busy", 0, busy[0], 0);
      check("midframe_reset_ready", 0, ready[0], 0);
      repeat (2) @(negedge inclk);
      rst_n = 1'b1;
      @(posedge inclk);
      #1;
      check("ready_after_midframe_reset", 0, ready[0], 1);
      check("on_after_midframe_reset", 0, on_o[0], 0);
      repeat (100) @(negedge inclk);
      check("no_done_from_abandoned_frame", 0, done_cnt[0] - d0, 0);

      // Randomized traffic.
      fork
         rand_traffic(0, 10);
         rand_traffic(1, 30);
      join

      repeat (5) @(negedge inclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
